// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph row reader.
//   GLYPH_W / GLYPH_H : default glyph geometry (pixels per row, rows per glyph)
//   ADDR_W            : default PROM row address width
//   state_t           : FSM state encoding, also exported on the debug port
package glyph_pkg;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;
    localparam int ADDR_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/glyph_row_shifter.sv
// Row register and column counter for one glyph row.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture row_in, restart at column 0
//   row_in     : PROM row bitmap, index 0 = leftmost pixel
//   advance    : step to the next column (ignored on the last column)
//   pix_on     : pixel value at the current column
//   col        : current column
//   last_col   : current column is the rightmost one
module glyph_row_shifter #(
    parameter int GLYPH_W = 16,
    parameter int COL_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [0:GLYPH_W-1] row_in,
    input  logic               advance,
    output logic               pix_on,
    output logic [COL_W-1:0]   col,
    output logic               last_col
);

    logic [0:GLYPH_W-1] row_q;
    logic [COL_W-1:0]   col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (load) begin
            row_q <= row_in;
            col_q <= '0;
        end else if (advance && !last_col) begin
            col_q <= col_q + COL_W'(1);
        end
    end

    assign col      = col_q;
    assign last_col = (col_q == COL_W'(GLYPH_W - 1));
    assign pix_on   = row_q[col_q];

endmodule

// File: rtl/glyph_row_reader.sv
// Glyph PROM reader: fetches each row of a glyph and streams it out one
// pixel per beat with absolute screen coordinates.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : render request, accepted only while idle
//   origin_x/origin_y  : glyph top-left corner, latched on accepted start
//   row_addr           : row address to the glyph PROM
//   row_data           : PROM row bitmap (combinational from row_addr)
//   pix_valid/pix_ready: pixel stream handshake
//   pix_x/pix_y/pix_on : pixel coordinates (wrapping) and value
//   busy               : high whenever not idle
//   done               : single-cycle pulse when the glyph is complete
//   dbg_state          : current FSM state (glyph_pkg::state_t encoding)
//
// Handshake: a beat transfers on a rising edge where pix_valid && pix_ready.
// pix_valid is a flop and never looks at pix_ready; while a beat is offered
// and not taken, pix_x/pix_y/pix_on stay unchanged because the column, row
// and origin registers only move on a transfer.
module glyph_row_reader #(
    parameter int GLYPH_W    = glyph_pkg::GLYPH_W,
    parameter int GLYPH_H    = glyph_pkg::GLYPH_H,
    parameter int ADDR_W     = glyph_pkg::ADDR_W,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int SKIP_BLANK = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [X_W-1:0]     origin_x,
    input  logic [Y_W-1:0]     origin_y,
    output logic [ADDR_W-1:0]  row_addr,
    input  logic [0:GLYPH_W-1] row_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic               pix_on,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    import glyph_pkg::*;

    localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  row_q;
    logic [X_W-1:0]     ox_q;
    logic [Y_W-1:0]     oy_q;
    logic               pix_valid_q;

    logic               latch;
    logic               load;
    logic               advance;
    logic               row_inc;
    logic               last_col;
    logic               last_row;
    logic               row_blank;
    logic [COL_W-1:0]   col;

    assign last_row  = (row_q == ADDR_W'(GLYPH_H - 1));
    assign row_blank = (SKIP_BLANK != 0) && (row_data == '0);

    // Next-state logic. "Row advance" appears in two places (blank row in
    // LOAD, last column in SHIFT) and behaves the same in both.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        row_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load = 1'b1;
                if (row_blank) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        row_inc = 1'b1;
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (pix_ready) begin
                    if (!last_col) begin
                        advance = 1'b1;
                    end else if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        row_inc = 1'b1;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_valid_q <= (state_d == ST_SHIFT);
            if (latch) begin
                ox_q  <= origin_x;
                oy_q  <= origin_y;
                row_q <= '0;
            end else if (row_inc) begin
                row_q <= row_q + ADDR_W'(1);
            end
        end
    end

    glyph_row_shifter #(
        .GLYPH_W (GLYPH_W),
        .COL_W   (COL_W)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .row_in   (row_data),
        .advance  (advance),
        .pix_on   (pix_on),
        .col      (col),
        .last_col (last_col)
    );

    // Coordinates wrap by truncation to the output width.
    assign pix_x     = ox_q + X_W'(col);
    assign pix_y     = oy_q + Y_W'(row_q);
    assign row_addr  = row_q;
    assign pix_valid = pix_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_glyph_row_reader.sv
module tb_glyph_row_reader;

  localparam int X_W = 10;
  localparam int Y_W = 10;
  localparam int W   = X_W + Y_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (SKIP_BLANK=0) ----------------
  logic           start0;
  logic [X_W-1:0] ox0;
  logic [Y_W-1:0] oy0;
  logic [3:0]     row_addr0;
  logic [0:15]    row_data0;
  logic           pix_valid0, pix_ready0, pix_on0, busy0, done0;
  logic [X_W-1:0] pix_x0;
  logic [Y_W-1:0] pix_y0;
  logic [2:0]     dbg0;
  logic [0:15]    glyph0 [16];
  assign row_data0 = glyph0[row_addr0];

  glyph_row_reader #(.X_W(X_W), .Y_W(Y_W), .SKIP_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .origin_x(ox0), .origin_y(oy0),
    .row_addr(row_addr0), .row_data(row_data0), .pix_valid(pix_valid0),
    .pix_ready(pix_ready0), .pix_x(pix_x0), .pix_y(pix_y0), .pix_on(pix_on0),
    .busy(busy0), .done(done0), .dbg_state(dbg0)
  );

  // ---------------- DUT 1 (SKIP_BLANK=1) ----------------
  logic           start1;
  logic [X_W-1:0] ox1;
  logic [Y_W-1:0] oy1;
  logic [3:0]     row_addr1;
  logic [0:15]    row_data1;
  logic           pix_valid1, pix_ready1, pix_on1, busy1, done1;
  logic [X_W-1:0] pix_x1;
  logic [Y_W-1:0] pix_y1;
  logic [2:0]     dbg1;
  logic [0:15]    glyph1 [16];
  assign row_data1 = glyph1[row_addr1];

  glyph_row_reader #(.X_W(X_W), .Y_W(Y_W), .SKIP_BLANK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .origin_x(ox1), .origin_y(oy1),
    .row_addr(row_addr1), .row_data(row_data1), .pix_valid(pix_valid1),
    .pix_ready(pix_ready1), .pix_x(pix_x1), .pix_y(pix_y1), .pix_on(pix_on1),
    .busy(busy1), .done(done1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int beats0, beats1, ons0;
  int rdy_mode = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected beats for a whole glyph, derived from the bench's PROM image.
  function automatic void push_exp(input int sel, input logic [X_W-1:0] ox, input logic [Y_W-1:0] oy);
    logic [0:15] g;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    for (int r = 0; r < 16; r++) begin
      g = (sel == 0) ? glyph0[r] : glyph1[r];
      if (!(sel == 1 && g == 16'h0000)) begin
        for (int c = 0; c < 16; c++) begin
          x = ox + X_W'(c);
          y = oy + Y_W'(r);
          if (sel == 0) exp_q0.push_back({x, y, g[c]});
          else          exp_q1.push_back({x, y, g[c]});
        end
      end
    end
  endfunction

  // ---------------- ready drivers ----------------
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   pk = 0;
  initial begin
    pix_ready0 = 1'b1;
    pix_ready1 = 1'b1;
  end
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      pix_ready0 = pat[pk];
      pk = (pk + int'($urandom_range(1, 2))) % 4;
    end else begin
      pix_ready0 = 1'b1;
    end
  end

  // ---------------- monitors ----------------
  logic [W-1:0] held0, cur0, e0, cur1, e1;
  logic         held0_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held0_v = 1'b0;
    end else if (pix_valid0) begin
      cur0 = {pix_x0, pix_y0, pix_on0};
      if (held0_v) chk("hold0", 32'(cur0), 32'(held0));
      if (!pix_ready0) begin
        held0   = cur0;
        held0_v = 1'b1;
      end else begin
        held0_v = 1'b0;
        beats0++;
        if (pix_on0) ons0++;
        if (exp_q0.size() == 0) begin
          chk("unexpected_beat0", 32'(cur0), 32'hFFFF_FFFF);
        end else begin
          e0 = exp_q0.pop_front();
          chk("beat0", 32'(cur0), 32'(e0));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && pix_valid1 && pix_ready1) begin
      cur1 = {pix_x1, pix_y1, pix_on1};
      beats1++;
      if (exp_q1.size() == 0) begin
        chk("unexpected_beat1", 32'(cur1), 32'hFFFF_FFFF);
      end else begin
        e1 = exp_q1.pop_front();
        chk("beat1", 32'(cur1), 32'(e1));
      end
    end
  end

  // ---------------- driver task ----------------
  // exp_done < 0 : only require that done arrives within the limit.
  task automatic render(input int sel, input logic [X_W-1:0] ox, input logic [Y_W-1:0] oy,
                        input int exp_done, input int exp_beats, input int glitch_cyc,
                        input int limit);
    int done_cyc;
    int ndone;
    logic d, b;
    done_cyc = -1;
    ndone    = 0;
    push_exp(sel, ox, oy);
    if (sel == 0) begin beats0 = 0; ons0 = 0; end else beats1 = 0;
    @(posedge clk); #1;
    if (sel == 0) begin ox0 = ox; oy0 = oy; start0 = 1'b1; end
    else          begin ox1 = ox; oy1 = oy; start1 = 1'b1; end
    @(posedge clk); #1;  // start-sampling edge
    start0 = 1'b0;
    start1 = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (glitch_cyc > 0 && n == glitch_cyc) begin
        start0 = 1'b1; ox0 = 10'd500; oy0 = 10'd400;
      end else if (glitch_cyc > 0 && n == glitch_cyc + 1) begin
        start0 = 1'b0;
      end
      d = (sel == 0) ? done0 : done1;
      b = (sel == 0) ? busy0 : busy1;
      if (d) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = n;
          chk("busy_at_done", 32'(b), 32'd1);
        end
      end
      if (done_cyc > 0 && n == done_cyc + 1) chk("busy_after_done", 32'(b), 32'd0);
      if (done_cyc > 0 && n >= done_cyc + 4) break;
    end
    if (exp_done > 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    else              chk("done_seen", 32'(done_cyc > 0), 32'd1);
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("beat_count", 32'((sel == 0) ? beats0 : beats1), 32'(exp_beats));
    chk("queue_empty", 32'((sel == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int valid_seen;

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; ox0 = '0; oy0 = '0;
    start1 = 1'b0; ox1 = '0; oy1 = '0;
    for (int r = 0; r < 16; r++) begin
      glyph0[r] = 16'h8001;
      glyph1[r] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    chk("rst_row_addr", 32'(row_addr0), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid0), 32'd0);
    chk("rst_xy_on", 32'({pix_x0, pix_y0, pix_on0}), 32'd0);
    chk("rst_busy_done", 32'({busy0, done0, busy1, done1}), 32'd0);
    chk("rst_state", 32'(dbg0), 32'd0);
    rst_n = 1'b1;

    // 8001 glyph at (100,50), full throughput: x=100 and x=115 lit.
    render(0, 10'd100, 10'd50, 289, 256, 0, 400);
    chk("on_count", 32'(ons0), 32'd32);

    // Same glyph under backpressure; scoreboard demands the identical sequence.
    rdy_mode = 1;
    render(0, 10'd100, 10'd50, -1, 256, 0, 2000);
    rdy_mode = 0;

    // Start pulse in row 3 SHIFT (cycles 57..72) with another origin: ignored.
    for (int r = 0; r < 16; r++) glyph0[r] = 16'h0F0F ^ 16'(r << 4);
    render(0, 10'd30, 10'd40, 289, 256, 60, 400);

    // Wrap: column 4 gives x=0, row 9 gives y=0.
    for (int r = 0; r < 16; r++) glyph0[r] = 16'hA5C3;
    render(0, 10'd1020, 10'd1015, 289, 256, 0, 400);

    // SKIP_BLANK: only row 7 lit -> 16 beats at y=307, done in cycle 49.
    glyph1[7] = 16'hFFFF;
    render(1, 10'd200, 10'd300, 49, 16, 0, 200);
    // All blank -> no beats, done in cycle 33.
    glyph1[7] = 16'h0000;
    render(1, 10'd5, 10'd5, 33, 0, 0, 100);

    // Asynchronous reset in row 5 SHIFT (cycles 93..108).
    for (int r = 0; r < 16; r++) glyph0[r] = 16'h8001;
    push_exp(0, 10'd100, 10'd50);
    @(posedge clk); #1;
    ox0 = 10'd100; oy0 = 10'd50; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (98) @(negedge clk);
    chk("pre_rst_valid", 32'(pix_valid0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(pix_valid0), 32'd0);
    chk("async_rst_row_addr", 32'(row_addr0), 32'd0);
    chk("async_rst_xy_on", 32'({pix_x0, pix_y0, pix_on0}), 32'd0);
    chk("async_rst_busy_done", 32'({busy0, done0}), 32'd0);
    exp_q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    valid_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (pix_valid0 || busy0) valid_seen++;
    end
    chk("idle_after_rst", 32'(valid_seen), 32'd0);
    chk("state_after_rst", 32'(dbg0), 32'd0);
    render(0, 10'd7, 10'd9, 289, 256, 0, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
